// File: rtl/neuron_layer_scheduler_pkg.sv
// rtl/neuron_layer_scheduler_pkg.sv - shared sizes and FSM encoding for the layer scheduler
package neuron_layer_scheduler_pkg;

    localparam int NUM_NEURONS  = 10;
    localparam int NUM_BATCHES  = 49;
    localparam int NUM_LANES    = 16;
    localparam int PIXEL_WIDTH  = 10;
    localparam int WEIGHT_WIDTH = 19;
    localparam int OUTPUT_WIDTH = 26;

    localparam int NEURON_IDX_W = 4;
    localparam int CNT_W        = 6;
    localparam int PIX_ADDR_W   = 6;
    localparam int WT_ADDR_W    = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FINISH = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/neuron_layer_scheduler_argmax.sv
// rtl/neuron_layer_scheduler_argmax.sv - running signed argmax over per-neuron results
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load_i        present a new candidate this cycle
//   first_i       candidate is the first of a pass; loads unconditionally
//   value_i       signed candidate value
//   idx_i         candidate index
//   best_idx_o    index of the best candidate so far
module sched_argmax
    import neuron_layer_scheduler_pkg::*;
#(
    parameter int VALUE_WIDTH = OUTPUT_WIDTH,
    parameter int IDX_WIDTH   = NEURON_IDX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic                          first_i,
    input  logic signed [VALUE_WIDTH-1:0] value_i,
    input  logic        [IDX_WIDTH-1:0]   idx_i,
    output logic        [IDX_WIDTH-1:0]   best_idx_o
);

    logic signed [VALUE_WIDTH-1:0] best_val_q;
    logic        [IDX_WIDTH-1:0]   best_idx_q;
    logic                          take;

    // Strictly greater: on a tie the earlier (lower) index is kept.
    assign take = load_i & (first_i | (value_i > best_val_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val_q <= '0;
            best_idx_q <= '0;
        end else if (take) begin
            best_val_q <= value_i;
            best_idx_q <= idx_i;
        end
    end

    assign best_idx_o = best_idx_q;

endmodule

// File: rtl/neuron_layer_scheduler.sv
// rtl/neuron_layer_scheduler.sv - sequences batch reads per neuron, accumulates sums, adds bias, argmax
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a layer pass (IDLE only)
//   mem_ready             store accepts a read this cycle
//   rd_en/pix_addr/wt_addr batch read request and addresses
//   batch_valid/batch_sum in-order partial sums from the lane array
//   bias_in               flat per-neuron biases
//   results               flat per-neuron results
//   class_idx             index of the largest result
//   busy/done/overrun     status
module neuron_layer_scheduler
    import neuron_layer_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS  = neuron_layer_scheduler_pkg::NUM_NEURONS,
    parameter int NUM_BATCHES  = neuron_layer_scheduler_pkg::NUM_BATCHES,
    parameter int WEIGHT_WIDTH = neuron_layer_scheduler_pkg::WEIGHT_WIDTH,
    parameter int OUTPUT_WIDTH = neuron_layer_scheduler_pkg::OUTPUT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                mem_ready,
    output logic                                rd_en,
    output logic [PIX_ADDR_W-1:0]               pix_addr,
    output logic [WT_ADDR_W-1:0]                wt_addr,
    input  logic                                batch_valid,
    input  logic [OUTPUT_WIDTH-1:0]             batch_sum,
    input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] bias_in,
    output logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] results,
    output logic [NEURON_IDX_W-1:0]             class_idx,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun
);

    state_t                    state_q;
    logic [NEURON_IDX_W-1:0]   neuron_q;
    logic [CNT_W-1:0]          batch_q;
    logic [CNT_W-1:0]          ret_cnt_q;
    logic [OUTPUT_WIDTH-1:0]   acc_q;
    logic                      rd_en_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      overrun_q;
    logic [PIX_ADDR_W-1:0]     pix_addr_q;
    logic [WT_ADDR_W-1:0]      wt_addr_q;
    logic [NEURON_IDX_W-1:0]   class_idx_q;
    logic [OUTPUT_WIDTH-1:0]   res_q    [NUM_NEURONS];
    logic [WEIGHT_WIDTH-1:0]   bias_arr [NUM_NEURONS];

    logic                      rd_accept;
    logic                      ret_take;
    logic                      ret_drop;
    logic [OUTPUT_WIDTH-1:0]   acc_sum;
    logic [WEIGHT_WIDTH-1:0]   bias_cur;
    logic [OUTPUT_WIDTH-1:0]   bias_ext;
    logic [OUTPUT_WIDTH-1:0]   final_val;
    logic [NEURON_IDX_W-1:0]   best_idx;

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_flat
        assign bias_arr[g] = bias_in[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign results[g*OUTPUT_WIDTH +: OUTPUT_WIDTH] = res_q[g];
    end

    assign rd_accept = rd_en_q & mem_ready;
    // A return is only legal while issued reads outnumber returns; batch
    // and ret_cnt are both zero outside a pass, so strays there are dropped.
    assign ret_take  = batch_valid & (batch_q != ret_cnt_q);
    assign ret_drop  = batch_valid & (batch_q == ret_cnt_q);
    assign acc_sum   = acc_q + batch_sum;
    assign bias_cur  = bias_arr[neuron_q];
    assign bias_ext  = {{(OUTPUT_WIDTH-WEIGHT_WIDTH){bias_cur[WEIGHT_WIDTH-1]}}, bias_cur};
    assign final_val = acc_q + bias_ext;

    sched_argmax #(
        .VALUE_WIDTH (OUTPUT_WIDTH),
        .IDX_WIDTH   (NEURON_IDX_W)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_FINISH),
        .first_i    (neuron_q == '0),
        .value_i    (final_val),
        .idx_i      (neuron_q),
        .best_idx_o (best_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            neuron_q    <= '0;
            batch_q     <= '0;
            ret_cnt_q   <= '0;
            acc_q       <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            pix_addr_q  <= '0;
            wt_addr_q   <= '0;
            class_idx_q <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                res_q[n] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (ret_drop) begin
                overrun_q <= 1'b1;
            end
            if (ret_take) begin
                acc_q     <= acc_sum;
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_ISSUE;
                        neuron_q   <= '0;
                        batch_q    <= '0;
                        ret_cnt_q  <= '0;
                        acc_q      <= '0;
                        overrun_q  <= ret_drop;
                        rd_en_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        pix_addr_q <= '0;
                        wt_addr_q  <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (rd_accept) begin
                        batch_q <= batch_q + 1'b1;
                        if (batch_q == CNT_W'(NUM_BATCHES - 1)) begin
                            // Addresses hold on the last batch while idle.
                            rd_en_q <= 1'b0;
                            state_q <= ST_DRAIN;
                        end else begin
                            pix_addr_q <= pix_addr_q + 1'b1;
                            wt_addr_q  <= wt_addr_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave as the final return lands so FINISH sees the full sum.
                    if (ret_take && ret_cnt_q == CNT_W'(NUM_BATCHES - 1)) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    res_q[neuron_q] <= final_val;
                    acc_q           <= '0;
                    ret_cnt_q       <= '0;
                    batch_q         <= '0;
                    if (neuron_q == NEURON_IDX_W'(NUM_NEURONS - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        neuron_q   <= neuron_q + 1'b1;
                        state_q    <= ST_ISSUE;
                        rd_en_q    <= 1'b1;
                        pix_addr_q <= '0;
                        // Last address was n*49+48, so +1 is the next neuron's base.
                        wt_addr_q  <= wt_addr_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q      <= 1'b1;
                    class_idx_q <= best_idx;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en     = rd_en_q;
    assign pix_addr  = pix_addr_q;
    assign wt_addr   = wt_addr_q;
    assign class_idx = class_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// tb/tb_neuron_layer_scheduler.sv - directed scoreboard bench for neuron_layer_scheduler
module tb_neuron_layer_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mem_ready = 1'b0;
    logic         rd_en;
    logic [5:0]   pix_addr;
    logic [8:0]   wt_addr;
    logic         batch_valid = 1'b0;
    logic [25:0]  batch_sum = '0;
    logic [189:0] bias_in;
    logic [259:0] results;
    logic [3:0]   class_idx;
    logic         busy;
    logic         done;
    logic         overrun;

    neuron_layer_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_ready   (mem_ready),
        .rd_en       (rd_en),
        .pix_addr    (pix_addr),
        .wt_addr     (wt_addr),
        .batch_valid (batch_valid),
        .batch_sum   (batch_sum),
        .bias_in     (bias_in),
        .results     (results),
        .class_idx   (class_idx),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [25:0] nsum [10];
    logic [18:0] bias [10];
    always_comb begin
        bias_in = '0;
        for (int n = 0; n < 10; n++) bias_in[n*19 +: 19] = bias[n];
    end

    // Scoreboard of expected per-pass outputs.
    logic [25:0] exp_q[$];
    logic [3:0]  exp_cls_q[$];

    // Lane-array / memory responder.
    typedef struct {
        logic [25:0] sum;
        int          ready_at;
    } ret_t;
    ret_t pend[$];
    int ready_mode = 0;
    int lat_max = 1;
    int last_ready = 0;
    int acc_cnt = 0;
    int addr_err = 0;
    int rd_outside = 0;
    int exp_idx = 0;
    int pass_id = 0;
    int seen_pass = 0;
    int inj_req_cnt = 0;
    int inj_done_cnt = 0;

    always @(negedge clk) begin
        int   up;
        int   lat;
        int   nidx;
        ret_t e;
        up = cyc + 1;
        if (seen_pass != pass_id) begin
            seen_pass = pass_id;
            exp_idx = 0;
        end
        batch_valid = 1'b0;
        batch_sum   = '0;
        if (inj_req_cnt != inj_done_cnt) begin
            batch_valid = 1'b1;
            batch_sum   = 26'h40000;
            inj_done_cnt++;
        end else if (pend.size() > 0 && pend[0].ready_at <= up) begin
            batch_valid = 1'b1;
            batch_sum   = pend[0].sum;
            void'(pend.pop_front());
        end
        mem_ready = (ready_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rd_en && !busy) rd_outside++;
        if (rd_en && mem_ready) begin
            lat = $urandom_range(1, lat_max);
            e.ready_at = (up + lat > last_ready) ? up + lat : last_ready + 1;
            last_ready = e.ready_at;
            nidx = int'(wt_addr) / 49;
            e.sum = (nidx < 10) ? nsum[nidx] : '0;
            if (pix_addr != 6'(exp_idx % 49) || wt_addr != 9'(exp_idx)) addr_err++;
            exp_idx++;
            acc_cnt++;
            pend.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [25:0] s, input logic [18:0] b);
        for (int n = 0; n < 10; n++) begin
            nsum[n] = s;
            bias[n] = b;
        end
    endtask

    task automatic push_expected();
        logic [25:0]        r;
        logic signed [25:0] best;
        longint             v;
        int                 bi;
        best = '0;
        bi = 0;
        for (int n = 0; n < 10; n++) begin
            v = 49 * longint'($signed(nsum[n])) + longint'($signed(bias[n]));
            r = v[25:0];
            exp_q.push_back(r);
            if (n == 0 || $signed(r) > best) begin
                best = $signed(r);
                bi = n;
            end
        end
        exp_cls_q.push_back(4'(bi));
    endtask

    task automatic run_pass(input string name, input bit timed, input bit poke);
        int          base_acc;
        int          base_aerr;
        int          base_out;
        int          t0;
        int          done_cyc;
        bit          got;
        logic [25:0] r;
        logic [3:0]  c;
        push_expected();
        pass_id++;
        base_acc  = acc_cnt;
        base_aerr = addr_err;
        base_out  = rd_outside;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check({name, "_busy_start"}, busy, 1);
        check({name, "_overrun_clr"}, overrun, 0);
        got = 0;
        done_cyc = 0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            start = (poke && i == 100);
            if (done) begin
                got = 1;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        check({name, "_done_seen"}, got, 1);
        if (timed) check({name, "_done_cycle"}, done_cyc - t0, 511);
        for (int n = 0; n < 10; n++) begin
            r = exp_q.pop_front();
            check($sformatf("%s_res%0d", name, n), results[n*26 +: 26], r);
        end
        c = exp_cls_q.pop_front();
        check({name, "_class"}, class_idx, c);
        check({name, "_reads"}, acc_cnt - base_acc, 490);
        check({name, "_addr_err"}, addr_err - base_aerr, 0);
        check({name, "_rd_outside"}, rd_outside - base_out, 0);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        start = 1'b0;
        set_all(26'h40000, 19'h0);

        // Reset state
        @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_addr", {pix_addr, wt_addr}, 0);
        check("rst_class", class_idx, 0);
        check("rst_results", |results, 0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal pass: 1.0 per batch, zero bias, full-rate memory, latency 1
        ready_mode = 0;
        lat_max = 1;
        run_pass("A", 1, 0);
        check("A_res0_const", results[25:0], 26'hC40000);

        // Neuron 7 gets +0.5 bias; stalling memory, random latency, stray start
        set_all(26'h40000, 19'h0);
        bias[7] = 19'h20000;
        ready_mode = 1;
        lat_max = 5;
        run_pass("B", 0, 1);
        check("B_class7", class_idx, 7);

        // Reset at neuron 4 batch 20
        ready_mode = 0;
        lat_max = 1;
        pass_id++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (rd_en && wt_addr == 9'd216) got = 1;
        end
        check("mid_reach", got, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", {pix_addr, wt_addr}, 0);
        check("mid_rst_class", class_idx, 0);
        check("mid_rst_results", |results, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_late_overrun", overrun, 1);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (pend.size() == 0) got = 1;
        end
        check("mid_drain", got, 1);

        // Clean pass after reset; neurons 3 and 7 tie for the maximum
        set_all(26'h10000, 19'h0);
        nsum[3] = 26'h40000;
        nsum[7] = 26'h40000;
        run_pass("C", 1, 0);
        check("C_class3", class_idx, 3);

        // Stray return in IDLE
        @(posedge clk);
        #1 inj_req_cnt++;
        @(negedge clk);
        @(negedge clk);
        check("idle_overrun", overrun, 1);
        check("idle_busy", busy, 0);

        // Negative sums and bias: -1.0 x 49 + -1.0
        set_all(26'h3FC0000, 19'h40000);
        run_pass("D", 1, 0);
        check("D_res0_const", results[25:0], 26'h3380000);

        // Positive wrap
        set_all(26'h1FFFFFF, 19'h0);
        run_pass("E", 1, 0);
        check("E_res0_const", results[25:0], 26'h1FFFFCF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_layer_scheduler.md
NEURON_LAYER_SCHEDULER -- requirements
Module: neuron_layer_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, 10, output neurons sequenced per layer pass.
REQ-002 Parameter NUM_BATCHES, 49, lane batches per neuron (16 lanes x 49 = 784 inputs).
REQ-003 Parameter WEIGHT_WIDTH, 19, signed bias width (1 integer, 18 fraction bits).
REQ-004 Parameter OUTPUT_WIDTH, 26, signed accumulator/result width (8 integer, 18 fraction bits).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin a layer pass; sampled only in IDLE.
REQ-008 mem_ready  input  1  pixel/weight store accepts a read this cycle.
REQ-009 rd_en  output  1  batch read request; accepted when rd_en & mem_ready.
REQ-010 pix_addr  output  6  batch index 0..48.
REQ-011 wt_addr  output  9  neuron*49 + batch, 0..489.
REQ-012 batch_valid  input  1  lane-array partial sum valid; in-order returns, arbitrary latency.
REQ-013 batch_sum  input  OUTPUT_WIDTH  signed 16-lane partial sum.
REQ-014 bias_in  input  NUM_NEURONS*WEIGHT_WIDTH  flat biases, neuron n at [n*19 +: 19].
REQ-015 results  output  NUM_NEURONS*OUTPUT_WIDTH  flat per-neuron results, neuron n at [n*26 +: 26].
REQ-016 class_idx  output  4  index of maximum result.
REQ-017 busy  output  1  high from cycle after accepted start until DONE exits.
REQ-018 done  output  1  one-cycle pulse at pass completion.
REQ-019 overrun  output  1  sticky: batch_valid received with no outstanding request.

Function
REQ-020 FSM states IDLE, ISSUE, DRAIN, FINISH, DONE; IDLE with start=1 -> ISSUE, neuron=0, batch=0, counters/acc cleared, overrun cleared.
REQ-021 ISSUE: rd_en=1; each accepted read increments batch; on accepting batch 48 -> DRAIN.
REQ-022 rd_en=0 in all states except ISSUE; addresses hold last value when rd_en=0.
REQ-023 Every batch_valid in ISSUE/DRAIN/FINISH adds sign-correct batch_sum to acc and increments ret_cnt, including the cycle of issue.
REQ-024 DRAIN -> FINISH in the cycle after ret_cnt reaches 49 (acc includes all 49 sums).
REQ-025 FINISH (one cycle): results[neuron] = acc + bias sign-extended by 7 bits, modulo 2^26; acc, ret_cnt, batch cleared.
REQ-026 FINISH argmax: neuron 0 always loads best; neuron n>0 replaces best only if strictly greater (signed); ties keep lower index.
REQ-027 FINISH -> ISSUE with neuron+1 if neuron<NUM_NEURONS-1, else -> DONE.
REQ-028 DONE (one cycle): done=1, class_idx updated to best index; -> IDLE; busy=0 in IDLE.
REQ-029 start while not IDLE is ignored; results and class_idx hold until next FINISH/DONE write.
REQ-030 batch_valid when issued count equals ret_cnt (including IDLE) is discarded and sets overrun.
REQ-031 Accumulation wraps modulo 2^26; no saturation.
REQ-032 mem_ready low stalls ISSUE indefinitely without losing batch index.
REQ-033 Minimum pass time with mem_ready=1 and 1-cycle return latency: 10*(49+2)+1 cycles after start.

Reset
REQ-034 rst=1 forces IDLE, rd_en=0, busy=0, done=0, overrun=0, addresses=0, class_idx=0, results=0, acc and all counters 0, immediately and independently of clk.
REQ-035 Reset mid-pass abandons the pass; returns arriving after reset release set overrun.

Structure
REQ-036 Shared package holds NUM_NEURONS, NUM_BATCHES, NUM_LANES=16, PIXEL_WIDTH=10, WEIGHT_WIDTH, OUTPUT_WIDTH and the FSM state encoding.
REQ-037 One sub-module: sched_argmax (signed strict-greater compare, best value/index registers).
REQ-038 No multipliers inside this block; lane array is external.

Verification
REQ-039 mem_ready=1, latency 1, all batch_sum=1.0 (0x40000), bias 0 -> each result 49.0 (0xC40000), done at cycle 511, class_idx=0.
REQ-040 Neuron 7 bias +0.5, others 0, equal sums -> class_idx=7; neurons 3 and 7 equal max -> class_idx=3.
REQ-041 mem_ready toggling 50%, returns with random latency 1..5 -> same results as REQ-039, rd_en never 1 outside ISSUE, 490 accepted reads total.
REQ-042 Negative sums -1.0 each, bias -1.0 -> results -50.0; positive overflow 49 x 0x1FFFFFF-range sums wraps modulo 2^26.
REQ-043 batch_valid in IDLE -> overrun=1, acc unchanged; next start clears overrun.
REQ-044 rst pulse at neuron 4 batch 20 -> all outputs zero asynchronously; new start completes a clean pass.
